// File: rtl/pwm_fade_controller_if.sv
// Write port of the PWM fade controller: valid/ready handshake with per-channel
// target and rate fields.
interface pwm_fade_controller_if #(
  parameter int CH_WIDTH = 2
);
  logic                Wr_Valid;
  logic                Wr_Ready;
  logic [CH_WIDTH-1:0] Wr_Channel;
  logic [7:0]          Wr_Target;
  logic [7:0]          Wr_Rate;

  modport master (
    output Wr_Valid, Wr_Channel, Wr_Target, Wr_Rate,
    input  Wr_Ready
  );

  modport slave (
    input  Wr_Valid, Wr_Channel, Wr_Target, Wr_Rate,
    output Wr_Ready
  );
endinterface

// File: rtl/pwm_fade_controller.sv
// Multi-channel duty-cycle sequencer: ramps each channel toward its target,
// updating only in a short sweep window at the start of every 256-cycle period.
module pwm_fade_controller #(
  parameter int CHANNELS = 4,
  parameter int CH_WIDTH = 2
) (
  input  logic                    Clk,
  input  logic                    nReset,
  pwm_fade_controller_if.slave    wr,
  output logic [8*CHANNELS-1:0]   DutyCycle,
  output logic [CHANNELS-1:0]     Busy,
  output logic                    Period_Sync
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic       sync_q, sync_d;
  logic [7:0] cur_q  [CHANNELS];
  logic [7:0] cur_d  [CHANNELS];
  logic [7:0] tgt_q  [CHANNELS];
  logic [7:0] tgt_d  [CHANNELS];
  logic [7:0] rate_q [CHANNELS];
  logic [7:0] rate_d [CHANNELS];
  logic [7:0] pre_q  [CHANNELS];
  logic [7:0] pre_d  [CHANNELS];

  assign wr.Wr_Ready = (state_q == IDLE);
  assign Period_Sync = sync_q;

  always_comb begin
    p_d     = p_q + 8'd1;
    sync_d  = (p_q == 8'd254);
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    pre_d   = pre_q;

    case (state_q)
      IDLE:    if (p_q == 8'hFF) state_d = SWEEP;
      SWEEP:   if (p_q == 8'(CHANNELS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Writes and servicing never coincide: writes only in IDLE, service only in SWEEP.
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (state_q == IDLE) begin
        if (wr.Wr_Valid && (wr.Wr_Channel == CH_WIDTH'(k))) begin
          tgt_d[k]  = wr.Wr_Target;
          rate_d[k] = wr.Wr_Rate;
          pre_d[k]  = '0;
        end
      end else if (p_q == 8'(k)) begin
        if (cur_q[k] == tgt_q[k]) begin
          pre_d[k] = '0;
        end else if (pre_q[k] != 8'd0) begin
          pre_d[k] = pre_q[k] - 8'd1;
        end else if (rate_q[k] == 8'd0) begin
          cur_d[k] = tgt_q[k];
        end else begin
          cur_d[k] = (tgt_q[k] > cur_q[k]) ? cur_q[k] + 8'd1 : cur_q[k] - 8'd1;
          pre_d[k] = rate_q[k] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    DutyCycle = '0;
    Busy      = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      DutyCycle[8*k +: 8] = cur_q[k];
      Busy[k]             = (cur_q[k] != tgt_q[k]);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      p_q     <= '0;
      sync_q  <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cur_q[k]  <= '0;
        tgt_q[k]  <= '0;
        rate_q[k] <= '0;
        pre_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      sync_q  <= sync_d;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        cur_q[k]  <= cur_d[k];
        tgt_q[k]  <= tgt_d[k];
        rate_q[k] <= rate_d[k];
        pre_q[k]  <= pre_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Randomized bench for pwm_fade_controller against a period-level reference model,
// with directed jump/ramp/reversal/handshake/reset scenarios.
module tb_pwm_fade_controller;
  localparam int CHANNELS = 4;
  localparam int CH_WIDTH = 2;

  logic                  Clk = 1'b0;
  logic                  nReset;
  logic [8*CHANNELS-1:0] DutyCycle;
  logic [CHANNELS-1:0]   Busy;
  logic                  Period_Sync;

  pwm_fade_controller_if #(.CH_WIDTH(CH_WIDTH)) wr_if ();

  pwm_fade_controller #(.CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .wr          (wr_if),
    .DutyCycle   (DutyCycle),
    .Busy        (Busy),
    .Period_Sync (Period_Sync)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: channel values, period position, and whether a wrap has occurred.
  logic [7:0] m_cur  [CHANNELS];
  logic [7:0] m_tgt  [CHANNELS];
  logic [7:0] m_rate [CHANNELS];
  logic [7:0] m_pre  [CHANNELS];
  logic [7:0] m_p;
  bit         m_wrapped;

  function automatic bit m_sweep();
    return m_wrapped && (int'(m_p) < CHANNELS);
  endfunction

  function automatic logic [8*CHANNELS-1:0] m_duty();
    logic [8*CHANNELS-1:0] d;
    for (int k = 0; k < CHANNELS; k++) d[8*k +: 8] = m_cur[k];
    return d;
  endfunction

  function automatic logic [CHANNELS-1:0] m_busy();
    logic [CHANNELS-1:0] b;
    for (int k = 0; k < CHANNELS; k++) b[k] = (m_cur[k] != m_tgt[k]);
    return b;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < CHANNELS; k++) begin
      m_cur[k] = 0; m_tgt[k] = 0; m_rate[k] = 0; m_pre[k] = 0;
    end
    m_p = 0;
    m_wrapped = 0;
  endtask

  task automatic m_service(input int k);
    if (m_cur[k] == m_tgt[k])      m_pre[k] = 0;
    else if (m_pre[k] != 0)        m_pre[k] = m_pre[k] - 1;
    else if (m_rate[k] == 0)       m_cur[k] = m_tgt[k];
    else begin
      if (m_tgt[k] > m_cur[k]) m_cur[k] = m_cur[k] + 1;
      else                     m_cur[k] = m_cur[k] - 1;
      m_pre[k] = m_rate[k] - 1;
    end
  endtask

  task automatic m_edge(output bit accepted);
    accepted = 0;
    if (!m_sweep()) begin
      if (wr_if.Wr_Valid) begin
        accepted = 1;
        if (int'(wr_if.Wr_Channel) < CHANNELS) begin
          m_tgt[wr_if.Wr_Channel]  = wr_if.Wr_Target;
          m_rate[wr_if.Wr_Channel] = wr_if.Wr_Rate;
          m_pre[wr_if.Wr_Channel]  = 0;
        end
      end
    end else begin
      m_service(int'(m_p));
    end
    m_p = m_p + 1;
    if (m_p == 0) m_wrapped = 1;
  endtask

  // One clock: check outputs while the clock is low, advance DUT and model together.
  task automatic tick(output bit accepted);
    check_eq("ready", wr_if.Wr_Ready, !m_sweep());
    check_eq("duty", DutyCycle, m_duty());
    check_eq("busy", Busy, m_busy());
    check_eq("psync", Period_Sync, m_p == 8'd255);
    @(posedge Clk);
    m_edge(accepted);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    wr_if.Wr_Valid = 0;
    repeat (n) tick(acc);
  endtask

  task automatic wait_p(input int p);
    bit acc;
    wr_if.Wr_Valid = 0;
    for (int i = 0; i < 600; i++) begin
      if (int'(m_p) == p) break;
      tick(acc);
    end
  endtask

  task automatic write(input int ch, input int tgt, input int rate);
    bit acc;
    wr_if.Wr_Valid   = 1;
    wr_if.Wr_Channel = CH_WIDTH'(ch);
    wr_if.Wr_Target  = 8'(tgt);
    wr_if.Wr_Rate    = 8'(rate);
    for (int i = 0; i < 300; i++) begin
      tick(acc);
      if (acc) break;
    end
    wr_if.Wr_Valid = 0;
  endtask

  task automatic async_reset();
    #2 nReset = 0;
    wr_if.Wr_Valid = 0;
    #1;
    check_eq("rst_duty", DutyCycle, '0);
    check_eq("rst_busy", Busy, '0);
    check_eq("rst_ready", wr_if.Wr_Ready, 1);
    check_eq("rst_psync", Period_Sync, 0);
    m_reset();
    @(negedge Clk);
    nReset = 1;
  endtask

  initial begin
    int t, ch;
    wr_if.Wr_Valid = 0; wr_if.Wr_Channel = 0; wr_if.Wr_Target = 0; wr_if.Wr_Rate = 0;
    nReset = 0;
    m_reset();
    repeat (3) @(negedge Clk);
    check_eq("reset_duty", DutyCycle, '0);
    check_eq("reset_ready", wr_if.Wr_Ready, 1);
    nReset = 1;

    // Jump on ch0 written at P=10, applied at next sweep.
    wait_p(10);
    write(0, 200, 0);
    idle(300);
    check_eq("jump_ch0", DutyCycle[7:0], 8'd200);
    check_eq("jump_others", DutyCycle[31:8], '0);

    // Slow up-ramp on ch1.
    write(1, 3, 2);
    idle(256 * 6);
    check_eq("ramp_ch1", DutyCycle[15:8], 8'd3);
    check_eq("ramp_busy", Busy[1], 0);

    // ch2 down-ramp then reversal mid-ramp.
    write(2, 10, 0);
    idle(300);
    write(2, 5, 1);
    wait_p(10);
    idle(256);
    write(2, 12, 1);
    idle(256 * 6);
    check_eq("reverse_ch2", DutyCycle[23:16], 8'd12);

    // Write at P=255 lands in the immediately following sweep; Valid at P=0 waits.
    wait_p(255);
    write(3, 50, 0);
    wait_p(0);
    write(0, 7, 0);
    idle(300);
    write(0, 7, 3);
    idle(300);

    // Randomized traffic with a mid-run asynchronous reset.
    for (int it = 0; it < 80; it++) begin
      if (it == 40) async_reset();
      idle(int'($urandom_range(0, 300)));
      ch = int'($urandom_range(0, CHANNELS - 1));
      if ($urandom_range(0, 3) == 0) begin
        write(ch, int'($urandom_range(0, 255)), 0);
      end else begin
        t = int'(m_cur[ch]) + int'($urandom_range(0, 12)) - 6;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        write(ch, t, int'($urandom_range(0, 3)));
      end
    end
    idle(600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
